nonce_search_ctrl: RTL and testbench
====================================

Name: nonce_search_ctrl

Overview:
Sequential controller that drives the nonce input of the concatenator/verifier stage and consumes the hash stage's hash_done/H_out result.
- Issues nonces one at a time, starting from a base value.
- Waits for each hash to complete and compares the two most significant hash bytes against the target.
- Stops on the first hit, on exhaustion of the nonce range, or on abort.
- Sits beside the hash stage in the system top: output nonce feeds the concatenator; inputs come from the hasher.

Parameters:
NONCE_LAST, 32'hFFFF_FFFF, last nonce tried before declaring exhaustion
HASH_TIMEOUT, 64, cycles waited for hash_done before the same nonce is relaunched (minimum 2)

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  begin a search; honoured only in IDLE, FOUND or EXHAUST
abort  input  1  return to IDLE next cycle from any state
nonce_base  input  32  first nonce of a search, sampled when start is accepted
target  input  8  difficulty byte, sampled when start is accepted
hash_done  input  1  hash stage result valid
h_out  input  24  hash stage output, 3 bytes, byte2 = h_out[23:16]
nonce  output  32  nonce presented to the concatenator
hash_start  output  1  one-cycle pulse: nonce is stable, begin hashing
busy  output  1  high in LAUNCH and WAIT
found  output  1  high in FOUND
nonce_found  output  32  winning nonce, valid while found=1
exhausted  output  1  high in EXHAUST
timeout_err  output  1  sticky; set on any hash timeout, cleared by reset or an accepted start

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; nonce=0, nonce_found=0, internal target register=0, wait counter=0; all 1-bit outputs 0.
- States: IDLE, LAUNCH, WAIT, FOUND, EXHAUST.
- IDLE / FOUND / EXHAUST with start=1:
  - nonce<=nonce_base, target register<=target, timeout_err<=0, found/exhausted<=0.
  - Go to LAUNCH.
  - start in LAUNCH or WAIT is ignored.
- LAUNCH (one cycle): hash_start=1, wait counter<=0, go to WAIT. nonce does not change in LAUNCH or WAIT.
- WAIT, hash_done=1: evaluate hit = (h_out[23:16] < target_reg) && (h_out[15:8] < target_reg), unsigned.
  - Hit: nonce_found<=nonce, go to FOUND.
  - Else if nonce==NONCE_LAST: go to EXHAUST.
  - Else: nonce<=nonce+1 (32-bit, no wrap possible because of the NONCE_LAST check), go to LAUNCH.
- WAIT, hash_done=0: wait counter increments.
  - At HASH_TIMEOUT-1: timeout_err<=1, go to LAUNCH with the same nonce (retry, unlimited).
- hash_done outside WAIT is ignored.
- Latency:
  - start accepted at edge N gives hash_start=1 during cycle N+1.
  - hash_done seen in WAIT at cycle M gives found=1 from cycle M+1, or hash_start for the next nonce in cycle M+1.
- abort=1: next state IDLE; found/exhausted/busy go to 0. abort has priority over start and hash_done in the same cycle. nonce and nonce_found hold their values.
- FOUND and EXHAUST hold until start or abort.
- target_reg=0: hit is impossible; the search runs to EXHAUST.
- Reset mid-search: immediate return to reset values, regardless of clock.

Optional Feature:
Macro NONCE_STATS_EN.
- Defined: adds output attempts[31:0]. Cleared on reset and on an accepted start. Incremented by 1 on each hash_done consumed in WAIT. Timeouts are not counted. Saturates at 32'hFFFF_FFFF.
- Not defined: port and counter absent; all other behaviour identical.

Test Plan:
1. Reset, then start with nonce_base=0x10, target=0x20; hasher returns h_out=0x30_00_00 for nonces 0x10 and 0x11, and 0x05_1F_FF for 0x12 -> three hash_start pulses; found=1 with nonce_found=0x12 one cycle after the third hash_done; busy=0.
2. NONCE_LAST=0x0000_0003, nonce_base=0x2, every h_out=0xFF_FF_FF -> nonces 2 then 3 issued; exhausted=1 after the second hash_done; nonce stays at 3.
3. HASH_TIMEOUT=4, hasher silent for the first attempt -> hash_start repeats 4 cycles after the first with the same nonce; timeout_err=1; a later hit still gives found=1 and timeout_err remains 1.
4. abort and hash_done (with a hit) asserted in the same WAIT cycle -> next state IDLE; found=0; nonce_found unchanged.
5. Reset pulled low asynchronously mid-WAIT -> all outputs 0 before the next clock edge; start after release restarts cleanly from nonce_base.
6. With NONCE_STATS_EN defined, scenario 1 -> attempts=3 at found; a new start clears it to 0.

Source files
------------

// File: rtl/nonce_search_ctrl.sv
// Nonce search controller: issues nonces to the hash stage and stops on a hit, exhaustion or abort.
// Optional macro NONCE_STATS_EN adds a saturating attempts counter output.
module nonce_search_ctrl #(
  parameter logic [31:0] NONCE_LAST   = 32'hFFFF_FFFF,
  parameter int          HASH_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] nonce_base,
  input  logic [7:0]  target,
  input  logic        hash_done,
  input  logic [23:0] h_out,
  output logic [31:0] nonce,
  output logic        hash_start,
  output logic        busy,
  output logic        found,
  output logic [31:0] nonce_found,
  output logic        exhausted,
`ifdef NONCE_STATS_EN
  output logic [31:0] attempts,
`endif
  output logic        timeout_err
);

  localparam int CW = $clog2(HASH_TIMEOUT) + 1;
  // Relaunch when the incremented count would reach HASH_TIMEOUT-1, so a retry
  // hash_start follows the previous one by exactly HASH_TIMEOUT cycles.
  localparam logic [CW-1:0] CNT_LAST = CW'(HASH_TIMEOUT - 2);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_WAIT    = 3'd2,
    S_FOUND   = 3'd3,
    S_EXHAUST = 3'd4
  } state_t;

  state_t        state_r;
  logic [7:0]    target_r;
  logic [CW-1:0] wait_cnt_r;
  logic          hit_s;

  // Difficulty check on the two most significant hash bytes.
  always_comb begin
    hit_s = 1'b0;
    if ((h_out[23:16] < target_r) && (h_out[15:8] < target_r)) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end

  // Search FSM with registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= S_IDLE;
      nonce       <= 32'd0;
      nonce_found <= 32'd0;
      target_r    <= 8'd0;
      wait_cnt_r  <= '0;
      hash_start  <= 1'b0;
      busy        <= 1'b0;
      found       <= 1'b0;
      exhausted   <= 1'b0;
      timeout_err <= 1'b0;
`ifdef NONCE_STATS_EN
      attempts    <= 32'd0;
`endif
    end else begin
      hash_start <= 1'b0;
      if (abort) begin
        state_r   <= S_IDLE;
        busy      <= 1'b0;
        found     <= 1'b0;
        exhausted <= 1'b0;
      end else begin
        case (state_r)
          S_IDLE, S_FOUND, S_EXHAUST: begin
            if (start) begin
              nonce       <= nonce_base;
              target_r    <= target;
              timeout_err <= 1'b0;
              found       <= 1'b0;
              exhausted   <= 1'b0;
              busy        <= 1'b1;
              hash_start  <= 1'b1;
              state_r     <= S_LAUNCH;
`ifdef NONCE_STATS_EN
              attempts    <= 32'd0;
`endif
            end
          end
          S_LAUNCH: begin
            wait_cnt_r <= '0;
            state_r    <= S_WAIT;
          end
          S_WAIT: begin
            if (hash_done) begin
`ifdef NONCE_STATS_EN
              if (attempts != 32'hFFFF_FFFF) begin
                attempts <= attempts + 32'd1;
              end
`endif
              if (hit_s) begin
                nonce_found <= nonce;
                found       <= 1'b1;
                busy        <= 1'b0;
                state_r     <= S_FOUND;
              end else if (nonce == NONCE_LAST) begin
                exhausted <= 1'b1;
                busy      <= 1'b0;
                state_r   <= S_EXHAUST;
              end else begin
                nonce      <= nonce + 32'd1;
                hash_start <= 1'b1;
                state_r    <= S_LAUNCH;
              end
            end else if (wait_cnt_r == CNT_LAST) begin
              timeout_err <= 1'b1;
              hash_start  <= 1'b1;
              state_r     <= S_LAUNCH;
            end else begin
              wait_cnt_r <= wait_cnt_r + CW'(1);
            end
          end
          default: begin
            state_r <= S_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nonce_search_ctrl.sv
// Directed self-checking bench for nonce_search_ctrl (NONCE_LAST=0x13, HASH_TIMEOUT=4).
module tb_nonce_search_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [31:0] nonce_base;
  logic [7:0]  target;
  logic        hash_done;
  logic [23:0] h_out;
  logic [31:0] nonce;
  logic        hash_start;
  logic        busy;
  logic        found;
  logic [31:0] nonce_found;
  logic        exhausted;
  logic        timeout_err;
`ifdef NONCE_STATS_EN
  logic [31:0] attempts;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int hs_cnt = 0;
  int hs_mark;

  nonce_search_ctrl #(
    .NONCE_LAST  (32'h0000_0013),
    .HASH_TIMEOUT(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .nonce_base (nonce_base),
    .target     (target),
    .hash_done  (hash_done),
    .h_out      (h_out),
    .nonce      (nonce),
    .hash_start (hash_start),
    .busy       (busy),
    .found      (found),
    .nonce_found(nonce_found),
    .exhausted  (exhausted),
`ifdef NONCE_STATS_EN
    .attempts   (attempts),
`endif
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count hash_start pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (hash_start === 1'b1) hs_cnt <= hs_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; nonce_base = 32'd0;
    target = 8'd0; hash_done = 1'b0; h_out = 24'd0;
    #12;
    chk("rst_nonce", nonce, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_found", {31'd0, found}, 32'd0);
    chk("rst_nfound", nonce_found, 32'd0);
    chk("rst_hs", {31'd0, hash_start}, 32'd0);
    @(negedge clk); reset = 1'b1;
    tick();

    // Test 1: hit on the third nonce
    hs_mark = hs_cnt;
    nonce_base = 32'h10; target = 8'h20; start = 1'b1;
    tick(); start = 1'b0;
    chk("t1_hs0", {31'd0, hash_start}, 32'd1);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    chk("t1_n0", nonce, 32'h10);
    tick();
    chk("t1_hs_wait", {31'd0, hash_start}, 32'd0);
    hash_done = 1'b1; h_out = 24'h30_00_00;
    tick(); hash_done = 1'b0;
    chk("t1_hs1", {31'd0, hash_start}, 32'd1);
    chk("t1_n1", nonce, 32'h11);
    tick();
    hash_done = 1'b1; h_out = 24'h30_00_00;
    tick(); hash_done = 1'b0;
    chk("t1_n2", nonce, 32'h12);
    tick();
    hash_done = 1'b1; h_out = 24'h05_1F_FF;
    tick(); hash_done = 1'b0;
    chk("t1_found", {31'd0, found}, 32'd1);
    chk("t1_nfound", nonce_found, 32'h12);
    chk("t1_busy_end", {31'd0, busy}, 32'd0);
    chk("t1_pulses", hs_cnt - hs_mark, 32'd3);
`ifdef NONCE_STATS_EN
    chk("t1_attempts", attempts, 32'd3);
`endif
    hash_done = 1'b1; h_out = 24'hFF_FF_FF;
    tick(); hash_done = 1'b0;
    chk("t1_hold", {31'd0, found}, 32'd1);

    // Test 2: exhaustion at NONCE_LAST
    nonce_base = 32'h12; target = 8'h20; start = 1'b1;
    tick(); start = 1'b0;
    chk("t2_found_clr", {31'd0, found}, 32'd0);
`ifdef NONCE_STATS_EN
    chk("t2_attempts_clr", attempts, 32'd0);
`endif
    tick();
    hash_done = 1'b1; h_out = 24'hFF_FF_FF;
    tick(); hash_done = 1'b0;
    chk("t2_n1", nonce, 32'h13);
    tick();
    hash_done = 1'b1;
    tick(); hash_done = 1'b0;
    chk("t2_exh", {31'd0, exhausted}, 32'd1);
    chk("t2_nonce", nonce, 32'h13);
    chk("t2_busy", {31'd0, busy}, 32'd0);

    // Test 3: timeout retry, start ignored while busy, later hit
    nonce_base = 32'h05; target = 8'h20; start = 1'b1;
    tick(); start = 1'b0;
    chk("t3_exh_clr", {31'd0, exhausted}, 32'd0);
    tick();
    tick();
    nonce_base = 32'h99; start = 1'b1;
    tick(); start = 1'b0;
    chk("t3_hs_l3", {31'd0, hash_start}, 32'd0);
    chk("t3_ign_start", nonce, 32'h05);
    chk("t3_terr0", {31'd0, timeout_err}, 32'd0);
    tick();
    chk("t3_retry_hs", {31'd0, hash_start}, 32'd1);
    chk("t3_retry_n", nonce, 32'h05);
    chk("t3_terr1", {31'd0, timeout_err}, 32'd1);
    tick();
    hash_done = 1'b1; h_out = 24'h00_00_00;
    tick(); hash_done = 1'b0;
    chk("t3_found", {31'd0, found}, 32'd1);
    chk("t3_nfound", nonce_found, 32'h05);
    chk("t3_terr_sticky", {31'd0, timeout_err}, 32'd1);

    // Test 4: abort beats a hitting hash_done
    nonce_base = 32'h08; target = 8'h20; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    abort = 1'b1; hash_done = 1'b1; h_out = 24'h00_00_00;
    tick(); abort = 1'b0; hash_done = 1'b0;
    chk("t4_found", {31'd0, found}, 32'd0);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_nfound", nonce_found, 32'h05);
    chk("t4_nonce", nonce, 32'h08);
    tick();
    chk("t4_idle_hs", {31'd0, hash_start}, 32'd0);

    // Test 5: asynchronous reset mid-WAIT, then clean restart
    nonce_base = 32'h0A; target = 8'h20; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    #2 reset = 1'b0;
    #1;
    chk("t5_nonce", nonce, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); reset = 1'b1;
    nonce_base = 32'h0C; target = 8'h20; start = 1'b1;
    tick(); start = 1'b0;
    chk("t5_restart_hs", {31'd0, hash_start}, 32'd1);
    chk("t5_restart_n", nonce, 32'h0C);
    tick();
    hash_done = 1'b1; h_out = 24'h1F_1F_00;
    tick(); hash_done = 1'b0;
    chk("t5_nfound", nonce_found, 32'h0C);

    // Test 6: target zero never hits, runs to exhaustion
    nonce_base = 32'h13; target = 8'h00; start = 1'b1;
    tick(); start = 1'b0;
    tick();
    hash_done = 1'b1; h_out = 24'h00_00_00;
    tick(); hash_done = 1'b0;
    chk("t6_found", {31'd0, found}, 32'd0);
    chk("t6_exh", {31'd0, exhausted}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
